// File: rtl/imm_gen_pipe_if.sv
// Decode-to-execute immediate bundle between control/decode and the E register.
// CompressedD exists only when IMM_GEN_RVC_EN is defined.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic [31:0]     InstrD;
    logic [2:0]      ImmSrcD;
    logic            ValidD;
    logic            StallE;
    logic            FlushE;
`ifdef IMM_GEN_RVC_EN
    logic            CompressedD;
`endif
    logic [XLEN-1:0] ImmExtE;
    logic            ValidE;
    logic            IllegalImmE;

    modport master (
        output InstrD,
        output ImmSrcD,
        output ValidD,
        output StallE,
        output FlushE,
`ifdef IMM_GEN_RVC_EN
        output CompressedD,
`endif
        input  ImmExtE,
        input  ValidE,
        input  IllegalImmE
    );

    modport slave (
        input  InstrD,
        input  ImmSrcD,
        input  ValidD,
        input  StallE,
        input  FlushE,
`ifdef IMM_GEN_RVC_EN
        input  CompressedD,
`endif
        output ImmExtE,
        output ValidE,
        output IllegalImmE
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Immediate generator with its execute-stage register (stall/flush aware).
// Define IMM_GEN_RVC_EN to add 16-bit compressed immediate formats.
module imm_gen_pipe #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_IMM = '0
) (
    input logic           clk,
    input logic           rst_n,
    imm_gen_pipe_if.slave bus
);

    if (XLEN != 32 && XLEN != 64) begin : gBadXlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [31:0]     instr;
    logic [2:0]      src;
    logic [XLEN-1:0] immBase;
    logic            undefBase;
    logic [XLEN-1:0] immNext;
    logic            undefNext;
    logic            unusedBits;

    assign instr      = bus.InstrD;
    assign src        = bus.ImmSrcD;
    assign unusedBits = ^instr[6:0];

    always_comb begin
        immBase   = '0;
        undefBase = 1'b0;
        unique case (src)
            3'd0: immBase = XLEN'($signed(instr[31:20]));
            3'd1: immBase = XLEN'($signed({instr[31:25], instr[11:7]}));
            3'd2: immBase = XLEN'($signed({instr[31], instr[7],
                                           instr[30:25], instr[11:8],
                                           1'b0}));
            3'd3: immBase = XLEN'($signed({instr[31], instr[19:12],
                                           instr[20], instr[30:21],
                                           1'b0}));
            3'd4: immBase = XLEN'($signed({instr[31:12], 12'h000}));
            3'd5: begin
                // RV64 shifts use a 6-bit shamt, RV32 only 5
                if (XLEN == 32) immBase = XLEN'(instr[24:20]);
                else            immBase = XLEN'(instr[25:20]);
            end
            3'd6: immBase = XLEN'(instr[19:15]);
            default: undefBase = 1'b1;
        endcase
    end

`ifdef IMM_GEN_RVC_EN
    logic [15:0]     c;
    logic [XLEN-1:0] immRvc;
    logic            undefRvc;

    assign c = instr[15:0];

    always_comb begin
        immRvc   = '0;
        undefRvc = 1'b0;
        unique case (src)
            3'd0: immRvc = XLEN'($signed({c[12], c[6:2]}));
            3'd1: immRvc = XLEN'({c[10:7], c[12:11], c[5], c[6], 2'b00});
            3'd2: immRvc = XLEN'({c[5], c[12:10], c[6], 2'b00});
            3'd3: immRvc = XLEN'($signed({c[12], c[8], c[10:9], c[6],
                                          c[7], c[2], c[11], c[5:3],
                                          1'b0}));
            3'd4: immRvc = XLEN'($signed({c[12], c[6:5], c[2],
                                          c[11:10], c[4:3], 1'b0}));
            3'd5: immRvc = XLEN'({c[12], c[6:2]});
            default: undefRvc = 1'b1;
        endcase
    end

    assign immNext   = bus.CompressedD ? immRvc   : immBase;
    assign undefNext = bus.CompressedD ? undefRvc : undefBase;
`else
    assign immNext   = immBase;
    assign undefNext = undefBase;
`endif

    logic [XLEN-1:0] immE;
    logic            validE;
    logic            illegalE;

    // Flush wins over stall so a squashed slot never keeps stale data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            immE     <= RESET_IMM;
            validE   <= 1'b0;
            illegalE <= 1'b0;
        end else if (bus.FlushE) begin
            immE     <= RESET_IMM;
            validE   <= 1'b0;
            illegalE <= 1'b0;
        end else if (!bus.StallE) begin
            immE     <= immNext;
            validE   <= bus.ValidD;
            illegalE <= bus.ValidD & undefNext;
        end
    end

    assign bus.ImmExtE     = immE;
    assign bus.ValidE      = validE;
    assign bus.IllegalImmE = illegalE;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe at XLEN=32 and XLEN=64.
// Define IMM_GEN_RVC_EN to also exercise compressed formats.
module tb_imm_gen_pipe;

    localparam logic [63:0] RST64 = 64'h0000_0000_0000_1234;

    logic clk;
    logic rst_n;
    int   errs;
    int   checks;

    imm_gen_pipe_if #(.XLEN(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64)) b64 ();

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b32)
    );

    imm_gen_pipe #(.XLEN(64), .RESET_IMM(RST64)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setIn(input logic [31:0] i, input logic [2:0] s,
                         input logic v, input logic st, input logic fl);
        b32.InstrD = i; b32.ImmSrcD = s; b32.ValidD = v;
        b32.StallE = st; b32.FlushE = fl;
        b64.InstrD = i; b64.ImmSrcD = s; b64.ValidD = v;
        b64.StallE = st; b64.FlushE = fl;
`ifdef IMM_GEN_RVC_EN
        b32.CompressedD = 1'b0;
        b64.CompressedD = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        setIn(32'hFFF00093, 3'd0, 1'b1, 1'b1, 1'b1);
        step();
        checks += 6;
        if (b32.ImmExtE !== 32'h0) begin
            errs++; $display("FAIL reset imm32 got %h want 0", b32.ImmExtE);
        end
        if (b32.ValidE !== 1'b0) begin
            errs++; $display("FAIL reset valid32 got %b want 0", b32.ValidE);
        end
        if (b32.IllegalImmE !== 1'b0) begin
            errs++; $display("FAIL reset ill32 got %b want 0", b32.IllegalImmE);
        end
        if (b64.ImmExtE !== RST64) begin
            errs++; $display("FAIL reset imm64 got %h want %h", b64.ImmExtE, RST64);
        end
        if (b64.ValidE !== 1'b0) begin
            errs++; $display("FAIL reset valid64 got %b want 0", b64.ValidE);
        end
        if (b64.IllegalImmE !== 1'b0) begin
            errs++; $display("FAIL reset ill64 got %b want 0", b64.IllegalImmE);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_itype();
        setIn(32'hFFF00093, 3'd0, 1'b1, 1'b0, 1'b0);
        step();
        checks += 4;
        if (b32.ImmExtE !== 32'hFFFF_FFFF) begin
            errs++; $display("FAIL itype imm32 got %h want ffffffff", b32.ImmExtE);
        end
        if (b32.ValidE !== 1'b1) begin
            errs++; $display("FAIL itype valid32 got %b want 1", b32.ValidE);
        end
        if (b32.IllegalImmE !== 1'b0) begin
            errs++; $display("FAIL itype ill32 got %b want 0", b32.IllegalImmE);
        end
        if (b64.ImmExtE !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errs++; $display("FAIL itype imm64 got %h want all ones", b64.ImmExtE);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [10];
        logic [2:0]  src [10];
        logic [31:0] exp [10];
        ins = '{32'hFE512E23, 32'h00112623, 32'h00000463, 32'hFE000EE3,
                32'h001000EF, 32'hFFDFF0EF, 32'h123452B7, 32'h03F51513,
                32'hFFFFD073, 32'h800002B7};
        src = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd4};
        exp = '{32'hFFFFFFFC, 32'h0000000C, 32'h00000008, 32'hFFFFFFFC,
                32'h00000800, 32'hFFFFFFFC, 32'h12345000, 32'h0000001F,
                32'h0000001F, 32'h80000000};
        for (int k = 0; k < 10; k++) begin
            setIn(ins[k], src[k], 1'b1, 1'b0, 1'b0);
            step();
            checks++;
            if (b32.ImmExtE !== exp[k] || b32.ValidE !== 1'b1) begin
                errs++;
                $display("FAIL b2b32[%0d] got %h/%b want %h/1",
                         k, b32.ImmExtE, b32.ValidE, exp[k]);
            end
        end
    endtask

    task automatic test_xlen64();
        logic [31:0] ins [6];
        logic [2:0]  src [6];
        logic [63:0] exp [6];
        ins = '{32'h800002B7, 32'h03F51513, 32'hFE000EE3, 32'hFFDFF0EF,
                32'hFFFFD073, 32'h7FF00093};
        src = '{3'd4, 3'd5, 3'd2, 3'd3, 3'd6, 3'd0};
        exp = '{64'hFFFFFFFF80000000, 64'h3F, 64'hFFFFFFFFFFFFFFFC,
                64'hFFFFFFFFFFFFFFFC, 64'h1F, 64'h7FF};
        for (int k = 0; k < 6; k++) begin
            setIn(ins[k], src[k], 1'b1, 1'b0, 1'b0);
            step();
            checks++;
            if (b64.ImmExtE !== exp[k]) begin
                errs++;
                $display("FAIL x64[%0d] got %h want %h", k, b64.ImmExtE, exp[k]);
            end
        end
    endtask

    task automatic test_stall_flush();
        setIn(32'hFE000EE3, 3'd2, 1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if (b32.ImmExtE !== 32'hFFFFFFFC) begin
            errs++; $display("FAIL sf load got %h want fffffffc", b32.ImmExtE);
        end
        for (int k = 0; k < 3; k++) begin
            setIn(32'h00500093 + 32'(k << 20), 3'd0, 1'b1, 1'b1, 1'b0);
            step();
            checks++;
            if (b32.ImmExtE !== 32'hFFFFFFFC || b32.ValidE !== 1'b1) begin
                errs++;
                $display("FAIL stall[%0d] got %h/%b want fffffffc/1",
                         k, b32.ImmExtE, b32.ValidE);
            end
        end
        setIn(32'h00500093, 3'd0, 1'b1, 1'b1, 1'b1);
        step();
        checks += 2;
        if (b32.ImmExtE !== 32'h0 || b32.ValidE !== 1'b0) begin
            errs++;
            $display("FAIL flush32 got %h/%b want 0/0", b32.ImmExtE, b32.ValidE);
        end
        if (b64.ImmExtE !== RST64 || b64.ValidE !== 1'b0) begin
            errs++;
            $display("FAIL flush64 got %h/%b want %h/0",
                     b64.ImmExtE, b64.ValidE, RST64);
        end
        setIn(32'h00500093, 3'd0, 1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if (b32.ImmExtE !== 32'h5 || b32.ValidE !== 1'b1) begin
            errs++;
            $display("FAIL postflush got %h/%b want 5/1", b32.ImmExtE, b32.ValidE);
        end
    endtask

    task automatic test_illegal();
        setIn(32'hFFFFFFFF, 3'd7, 1'b1, 1'b0, 1'b0);
        step();
        checks += 2;
        if (b32.IllegalImmE !== 1'b1 || b32.ImmExtE !== 32'h0) begin
            errs++;
            $display("FAIL ill32 got %b/%h want 1/0", b32.IllegalImmE, b32.ImmExtE);
        end
        if (b64.IllegalImmE !== 1'b1 || b64.ImmExtE !== 64'h0) begin
            errs++;
            $display("FAIL ill64 got %b/%h want 1/0", b64.IllegalImmE, b64.ImmExtE);
        end
        setIn(32'h00500093, 3'd0, 1'b1, 1'b1, 1'b0);
        step();
        checks++;
        if (b32.IllegalImmE !== 1'b1) begin
            errs++; $display("FAIL illhold got %b want 1", b32.IllegalImmE);
        end
        setIn(32'h00500093, 3'd0, 1'b1, 1'b0, 1'b1);
        step();
        checks++;
        if (b32.IllegalImmE !== 1'b0) begin
            errs++; $display("FAIL illflush got %b want 0", b32.IllegalImmE);
        end
        setIn(32'hFFFFFFFF, 3'd7, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (b32.IllegalImmE !== 1'b0 || b32.ImmExtE !== 32'h0
            || b32.ValidE !== 1'b0) begin
            errs++;
            $display("FAIL illnv got %b/%h/%b want 0/0/0",
                     b32.IllegalImmE, b32.ImmExtE, b32.ValidE);
        end
    endtask

    task automatic test_valid_low();
        setIn(32'h00500093, 3'd0, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (b32.ImmExtE !== 32'h5 || b32.ValidE !== 1'b0) begin
            errs++;
            $display("FAIL vlow got %h/%b want 5/0", b32.ImmExtE, b32.ValidE);
        end
    endtask

    task automatic test_reset_stall();
        setIn(32'hFE000EE3, 3'd2, 1'b1, 1'b0, 1'b0);
        step();
        setIn(32'h00500093, 3'd0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        step();
        checks += 2;
        if (b32.ImmExtE !== 32'h0 || b32.ValidE !== 1'b0) begin
            errs++;
            $display("FAIL rststall32 got %h/%b want 0/0", b32.ImmExtE, b32.ValidE);
        end
        if (b64.ImmExtE !== RST64) begin
            errs++;
            $display("FAIL rststall64 got %h want %h", b64.ImmExtE, RST64);
        end
        rst_n = 1'b1;
        setIn(32'h00500093, 3'd0, 1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if (b32.ImmExtE !== 32'h5 || b32.ValidE !== 1'b1) begin
            errs++;
            $display("FAIL rstrel got %h/%b want 5/1", b32.ImmExtE, b32.ValidE);
        end
    endtask

`ifdef IMM_GEN_RVC_EN
    task automatic test_rvc();
        logic [15:0] ins [5];
        logic [2:0]  src [5];
        logic [31:0] exp [5];
        logic        ill [5];
        ins = '{16'hB001, 16'h50FD, 16'h0020, 16'h0004, 16'hFFFF};
        src = '{3'd3, 3'd0, 3'd1, 3'd5, 3'd6};
        exp = '{32'hFFFFF800, 32'hFFFFFFFF, 32'h8, 32'h1, 32'h0};
        ill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 5; k++) begin
            setIn({16'h0, ins[k]}, src[k], 1'b1, 1'b0, 1'b0);
            b32.CompressedD = 1'b1;
            step();
            checks++;
            if (b32.ImmExtE !== exp[k] || b32.IllegalImmE !== ill[k]) begin
                errs++;
                $display("FAIL rvc[%0d] got %h/%b want %h/%b",
                         k, b32.ImmExtE, b32.IllegalImmE, exp[k], ill[k]);
            end
        end
    endtask
`endif

    initial begin
        errs   = 0;
        checks = 0;
        rst_n  = 1'b0;
        test_reset();
        test_itype();
        test_back_to_back();
        test_xlen64();
        test_stall_flush();
        test_illegal();
        test_valid_low();
        test_reset_stall();
`ifdef IMM_GEN_RVC_EN
        test_rvc();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
